// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand/result handshake bundle for the bit-serial adder controller
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences one full-adder cell across WIDTH-bit operands, one bit per clock
module serial_add_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input logic              clk,
   input logic              rst,
   serial_add_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, sum_r;
   logic             c, cout_r;
   logic [CNT_W-1:0] cnt;
   logic             ha0_s, ha0_c, ha1_s, ha1_c, c_nx, last;
   assign ha0_s = a_sr[0] ^ b_sr[0];
   assign ha0_c = a_sr[0] & b_sr[0];
   assign ha1_s = ha0_s ^ c;
   assign ha1_c = ha0_s & c;
   assign c_nx  = ha0_c | ha1_c;
   assign last  = cnt == CNT_W'(WIDTH - 1);
   // state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;
   // next-state and handshake outputs derived from the current state
   always_comb begin
      state_nx      = IDLE;
      bus.in_ready  = state == IDLE;
      bus.out_valid = state == DONE;
      bus.busy      = state == RUN;
      bus.sum       = sum_r;
      bus.cout      = cout_r;
      case (state)
         IDLE:    state_nx = bus.in_valid ? RUN : IDLE;
         RUN:     state_nx = last ? DONE : RUN;
         DONE:    state_nx = bus.out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   // operand capture, then one bit per edge through the adder cell into the sum register
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_r  <= '0;
         c      <= 1'b0;
         cout_r <= 1'b0;
         cnt    <= '0;
      end else if (state == IDLE && bus.in_valid) begin
         a_sr <= bus.a;
         b_sr <= bus.b;
         c    <= bus.cin;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         sum_r  <= {ha1_s, sum_r[WIDTH-1:1]};
         c      <= c_nx;
         cnt    <= last ? '0 : cnt + 1'b1;
         cout_r <= last ? c_nx : cout_r;
      end
   end
endmodule
